// File: rtl/uart_rx_framed_if.sv
// Receiver-side bundle for uart_rx_framed: serial line in, held word plus
// status flags out, and the consumer's ready handshake.
`timescale 1ns/1ps

interface uart_rx_framed_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  rx;
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;
  logic                  parity_error;
  logic                  framing_error;
  logic                  overrun;
  logic                  busy;
  logic                  break_det;

  // Receiver side: samples the line, presents the word and flags.
  modport master (
    input  rx, ready,
    output data, valid, parity_error, framing_error, overrun, busy, break_det
  );

  // Line driver / consumer side.
  modport slave (
    output rx, ready,
    input  data, valid, parity_error, framing_error, overrun, busy, break_det
  );
endinterface

// File: rtl/uart_rx_framed.sv
// uart_rx_framed: oversampling UART receiver with configurable data width,
// parity and stop bits, a one-word holding register with valid/ready
// handshake and overrun reporting.
// Optional feature macro: UART_RX_BREAK_DETECT_EN -- when defined, an
// all-zero frame is reported as a break pulse instead of a data word.
`timescale 1ns/1ps

module uart_rx_framed #(
  parameter int CLOCK_FREQ  = 50_000_000,
  parameter int BAUD_RATE   = 115_200,
  parameter int DATA_WIDTH  = 8,
  parameter int PARITY_MODE = 0,   // 0 none, 1 even, 2 odd
  parameter int STOP_BITS   = 1
) (
  input  logic            clock,
  input  logic            reset,
  uart_rx_framed_if.master bus
);

  localparam int TPB   = CLOCK_FREQ / BAUD_RATE;
  localparam int CNT_W = $clog2(TPB) + 1;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TPB);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(TPB / 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [3:0]       LAST_DATA = 4'(DATA_WIDTH - 1);
  localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);

`ifdef UART_RX_BREAK_DETECT_EN
  localparam bit BREAK_EN = 1'b1;
`else
  localparam bit BREAK_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // Line synchronizer
  logic r_sync1;
  logic r_rx_s;

  // Frame FSM and bit timing
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_tick;
  logic             w_last_data;
  logic             w_last_stop;
  logic             w_frame_end;
  logic             w_is_break;
  logic             w_exp_par;

  // Frame accumulation
  logic [3:0]            r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_perr_acc;
  logic                  r_ferr_acc;
  logic                  r_all_zero;
  logic                  r_brk_wait;
  logic                  r_done;

  // Holding register and status outputs
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_perr;
  logic                  r_ferr;
  logic                  r_overrun;
  logic                  r_break_det;

  // The counter reloads on every tick, so a tick is one cycle before it
  // would reach zero; this keeps bit spacing at exactly TPB cycles.
  assign w_tick      = (r_cnt == CNT_ONE);
  assign w_last_data = (r_bit_cnt == LAST_DATA);
  assign w_last_stop = (r_bit_cnt == LAST_STOP);
  assign w_exp_par   = (PARITY_MODE == 2) ? ~(^r_shift) : (^r_shift);
  assign w_is_break  = BREAK_EN && w_frame_end && r_all_zero && !r_rx_s;

  // Two-flop synchronizer on the asynchronous serial line.
  always_ff @(posedge clock) begin
    // NOTE: both flops reset to the idle level (1) so reset release never
    // looks like a start edge.
    if (reset) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make the two flops a real pipeline;
      // blocking here would collapse the synchronizer into one stage.
      r_sync1 <= bus.rx;
      r_rx_s  <= r_sync1;
    end
  end

  // FSM state and bit-timing counter register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state and counter logic; frame end is flagged at the last
  // stop-bit sample, returning to IDLE mid-bit.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // can leave one unassigned and infer a latch.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_frame_end = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (!r_rx_s && !r_brk_wait) begin
          w_state_nxt = START;
          w_cnt_nxt   = CNT_HALF;
        end
      end
      START: begin
        if (w_tick) begin
          if (r_rx_s) begin
            w_state_nxt = IDLE;   // start bit did not hold: glitch
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = DATA;
            w_cnt_nxt   = CNT_FULL;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      DATA: begin
        if (w_tick) begin
          w_cnt_nxt = CNT_FULL;
          if (w_last_data) w_state_nxt = (PARITY_MODE != 0) ? PARITY : STOP;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      PARITY: begin
        if (w_tick) begin
          w_cnt_nxt   = CNT_FULL;
          w_state_nxt = STOP;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      STOP: begin
        if (w_tick) begin
          if (w_last_stop) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            w_frame_end = 1'b1;
          end else begin
            w_cnt_nxt = CNT_FULL;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Bit sampling: shift data LSB first, accumulate parity/framing status and
  // the all-zero tracker used by break detection.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_perr_acc <= 1'b0;
      r_ferr_acc <= 1'b0;
      r_all_zero <= 1'b0;
      r_brk_wait <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      // Accumulators stay stable for the cycle after frame end because the
      // next START tick is at least TPB/2 cycles away.
      r_done <= w_frame_end;

      if (w_is_break)  r_brk_wait <= 1'b1;
      else if (r_rx_s) r_brk_wait <= 1'b0;

      if (w_tick) begin
        unique case (r_state)
          START: begin
            r_bit_cnt  <= '0;
            r_perr_acc <= 1'b0;
            r_ferr_acc <= 1'b0;
            r_all_zero <= 1'b1;
          end
          DATA: begin
            r_shift    <= {r_rx_s, r_shift[DATA_WIDTH-1:1]};
            r_all_zero <= r_all_zero & ~r_rx_s;
            r_bit_cnt  <= w_last_data ? 4'd0 : r_bit_cnt + 4'd1;
          end
          PARITY: begin
            r_perr_acc <= (r_rx_s != w_exp_par);
            r_all_zero <= r_all_zero & ~r_rx_s;
          end
          STOP: begin
            r_ferr_acc <= r_ferr_acc | ~r_rx_s;
            r_all_zero <= r_all_zero & ~r_rx_s;
            r_bit_cnt  <= r_bit_cnt + 4'd1;
          end
          default: ;
        endcase
      end
    end
  end

  // Holding register: load a finished frame if the slot is free or being
  // consumed this cycle, otherwise drop it and pulse overrun.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_perr      <= 1'b0;
      r_ferr      <= 1'b0;
      r_overrun   <= 1'b0;
      r_break_det <= 1'b0;
    end else begin
      r_overrun   <= 1'b0;
      r_break_det <= 1'b0;
      if (r_done && BREAK_EN && r_all_zero) begin
        r_break_det <= 1'b1;
        if (r_valid && bus.ready) r_valid <= 1'b0;
      end else if (r_done) begin
        if (!r_valid || bus.ready) begin
          r_data  <= r_shift;
          r_perr  <= r_perr_acc;
          r_ferr  <= r_ferr_acc;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && bus.ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.data          = r_data;
  assign bus.valid         = r_valid;
  assign bus.parity_error  = r_perr;
  assign bus.framing_error = r_ferr;
  assign bus.overrun       = r_overrun;
  assign bus.break_det     = r_break_det;
  assign bus.busy          = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_framed.sv
// Directed bench for uart_rx_framed at TPB=10: an 8N1 instance checked
// through a scoreboard, plus an even-parity instance checked directly.
`timescale 1ns/1ps

module tb_uart_rx_framed;

  localparam int CF  = 1_000_000;
  localparam int BR  = 100_000;
  localparam int TPB = 10;
  localparam int DW  = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  uart_rx_framed_if #(.DATA_WIDTH(DW)) if0 ();
  uart_rx_framed_if #(.DATA_WIDTH(DW)) if_par ();

  uart_rx_framed #(
    .CLOCK_FREQ(CF), .BAUD_RATE(BR), .DATA_WIDTH(DW),
    .PARITY_MODE(0), .STOP_BITS(1)
  ) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (if0)
  );

  uart_rx_framed #(
    .CLOCK_FREQ(CF), .BAUD_RATE(BR), .DATA_WIDTH(DW),
    .PARITY_MODE(1), .STOP_BITS(1)
  ) u_dut_par (
    .clock (clock),
    .reset (reset),
    .bus   (if_par)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t sb_q[$];
  int   n_total    = 0;
  int   n_bad      = 0;
  int   valid_seen = 0;
  int   ovr_seen   = 0;
  int   brk_seen   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor for the 8N1 instance: pops the scoreboard on each handshake.
  always @(negedge clock) begin
    if (!reset) begin
      if (if0.valid)     valid_seen++;
      if (if0.overrun)   ovr_seen++;
      if (if0.break_det) brk_seen++;
      if (if0.valid && if0.ready) begin
        if (sb_q.size() == 0) begin
          n_total++;
          n_bad++;
          $error("FAIL unexpected_word observed=%0h expected=none", if0.data);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("sb_data", 32'(if0.data), 32'(e.data));
          check("sb_parity_error", 32'(if0.parity_error), 32'(e.perr));
          check("sb_framing_error", 32'(if0.framing_error), 32'(e.ferr));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic set_rx(input bit par_dut, input logic v);
    if (par_dut) if_par.rx = v;
    else         if0.rx    = v;
  endtask

  task automatic send_bit(input bit par_dut, input logic v);
    set_rx(par_dut, v);
    tick(TPB);
  endtask

  task automatic send_frame(input bit par_dut, input logic [7:0] d,
                            input bit has_par, input logic par, input logic stop);
    send_bit(par_dut, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(par_dut, d[i]);
    if (has_par) send_bit(par_dut, par);
    send_bit(par_dut, stop);
    set_rx(par_dut, 1'b1);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    check("sb_drain", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic wait_par_valid(input int budget);
    int n = 0;
    while (!if_par.valid && n < budget) begin
      @(negedge clock);
      n++;
    end
    check("par_valid", 32'(if_par.valid), 32'd1);
  endtask

  initial begin
    int v0;
    int o0;
    int b0;

    if0.rx = 1'b1;    if0.ready = 1'b1;
    if_par.rx = 1'b1; if_par.ready = 1'b0;
    reset = 1'b1;
    tick(3);

    // Reset state
    check("rst_valid", 32'(if0.valid), 32'd0);
    check("rst_data", 32'(if0.data), 32'd0);
    check("rst_busy", 32'(if0.busy), 32'd0);
    check("rst_overrun", 32'(if0.overrun), 32'd0);
    check("rst_break", 32'(if0.break_det), 32'd0);
    check("rst_errors", {30'd0, if0.parity_error, if0.framing_error}, 32'd0);
    check("rst_par_valid", 32'(if_par.valid), 32'd0);
    reset = 1'b0;
    tick(5);

    // 8N1 words with ready=1
    sb_q.push_back({8'hA5, 1'b0, 1'b0});
    send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
    wait_drain(40);
    sb_q.push_back({8'h81, 1'b0, 1'b0});
    send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b1);
    wait_drain(40);
    tick(5);

    // 3-cycle glitch from idle
    v0 = valid_seen;
    set_rx(1'b0, 1'b0);
    tick(3);
    set_rx(1'b0, 1'b1);
    tick(2);
    check("glitch_busy_high", 32'(if0.busy), 32'd1);
    tick(10);
    check("glitch_busy_low", 32'(if0.busy), 32'd0);
    check("glitch_no_valid", 32'(valid_seen - v0), 32'd0);

    // Back-to-back with ready=0: second word dropped with one overrun pulse
    if0.ready = 1'b0;
    o0 = ovr_seen;
    sb_q.push_back({8'h11, 1'b0, 1'b0});
    send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
    send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
    tick(20);
    check("b2b_valid_held", 32'(if0.valid), 32'd1);
    check("b2b_data_held", 32'(if0.data), 32'h11);
    check("b2b_overrun_once", 32'(ovr_seen - o0), 32'd1);
    if0.ready = 1'b1;
    wait_drain(5);
    tick(2);
    check("b2b_valid_clear", 32'(if0.valid), 32'd0);

    // Stop bit low: framing error
    sb_q.push_back({8'h3C, 1'b0, 1'b1});
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
    wait_drain(40);
    tick(5);

    // Reset mid-frame, then a clean word
    v0 = valid_seen;
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    check("midframe_busy", 32'(if0.busy), 32'd1);
    set_rx(1'b0, 1'b1);
    reset = 1'b1;
    tick(3);
    check("midrst_busy", 32'(if0.busy), 32'd0);
    check("midrst_valid", 32'(if0.valid), 32'd0);
    reset = 1'b0;
    tick(30);
    check("midrst_abandoned", 32'(valid_seen - v0), 32'd0);
    check("midrst_errors", {30'd0, if0.parity_error, if0.framing_error}, 32'd0);
    sb_q.push_back({8'h55, 1'b0, 1'b0});
    send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b1);
    wait_drain(40);
    tick(5);

    // Line held low for 10 bit times
    v0 = valid_seen;
    b0 = brk_seen;
`ifdef UART_RX_BREAK_DETECT_EN
    set_rx(1'b0, 1'b0);
    tick(10 * TPB);
    set_rx(1'b0, 1'b1);
    tick(30);
    check("break_pulse", 32'(brk_seen - b0), 32'd1);
    check("break_no_valid", 32'(valid_seen - v0), 32'd0);
`else
    sb_q.push_back({8'h00, 1'b0, 1'b1});
    set_rx(1'b0, 1'b0);
    tick(10 * TPB);
    set_rx(1'b0, 1'b1);
    wait_drain(40);
    tick(30);
    check("break_tied_low", 32'(brk_seen - b0), 32'd0);
`endif
    check("break_idle", 32'(if0.busy), 32'd0);
    // Receiver re-arms after the line returns high
    sb_q.push_back({8'hC3, 1'b0, 1'b0});
    send_frame(1'b0, 8'hC3, 1'b0, 1'b0, 1'b1);
    wait_drain(40);

    // Even parity instance: 0x07 needs parity bit 1
    send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
    wait_par_valid(40);
    check("par_bad_data", 32'(if_par.data), 32'h07);
    check("par_bad_perr", 32'(if_par.parity_error), 32'd1);
    check("par_bad_ferr", 32'(if_par.framing_error), 32'd0);
    if_par.ready = 1'b1;
    tick(1);
    if_par.ready = 1'b0;
    tick(1);
    check("par_valid_clear", 32'(if_par.valid), 32'd0);
    send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
    wait_par_valid(40);
    check("par_good_data", 32'(if_par.data), 32'h07);
    check("par_good_perr", 32'(if_par.parity_error), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
